// File: rtl/cmd_scheduler_pkg.sv
// Shared state enum, command encodings and ASCII command bytes
// for the command scheduler.
package cmd_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ISSUE = 2'd2,
        GAP   = 2'd3
    } state_t;

    // One-hot command: bit0 clear, bit1 run, bit2 mode.
    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_CLEAR = 3'b001;
    localparam cmd_t CMD_RUN   = 3'b010;
    localparam cmd_t CMD_MODE  = 3'b100;

    localparam logic [7:0] CMD_RUN_CHAR   = 8'h72;
    localparam logic [7:0] CMD_CLEAR_CHAR = 8'h63;
    localparam logic [7:0] CMD_MODE_CHAR  = 8'h6D;

    // Fixed issue priority: clear > run > mode.
    function automatic cmd_t pick_cmd(input cmd_t pend);
        cmd_t c;
        c = '0;
        if (pend[0])      c = CMD_CLEAR;
        else if (pend[1]) c = CMD_RUN;
        else if (pend[2]) c = CMD_MODE;
        return c;
    endfunction

endpackage

// File: rtl/cmd_scheduler_decode.sv
// Combinational UART byte decoder: one-hot command plus unknown flag.
module cmd_decode
    import cmd_scheduler_pkg::*;
(
    input  logic [7:0] data_i,
    output cmd_t       cmd_o,
    output logic       unknown_o
);

    always_comb begin
        cmd_o     = '0;
        unknown_o = 1'b0;
        unique case (1'b1)
            (data_i == CMD_RUN_CHAR):   cmd_o = CMD_RUN;
            (data_i == CMD_CLEAR_CHAR): cmd_o = CMD_CLEAR;
            (data_i == CMD_MODE_CHAR):  cmd_o = CMD_MODE;
            default:                    unknown_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cmd_scheduler.sv
// Merges button pulses and UART command bytes into spaced command pulses.
// Define CMD_SCHEDULER_ERR_EN to add o_err / err_cnt for unknown bytes.
module cmd_scheduler
    import cmd_scheduler_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic       rx_empty,
    input  logic [7:0] rx_data,
    output logic       rx_pop,
    output logic       o_run,
    output logic       o_clear,
    output logic       o_mode,
`ifdef CMD_SCHEDULER_ERR_EN
    output logic       o_err,
    output logic [7:0] err_cnt,
`endif
    output logic       o_busy
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    cmd_t       pend_q, pend_d;
    cmd_t       cmd_q, cmd_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       rx_pop_q, rx_pop_d;
    logic       busy_q, busy_d;
    cmd_t       dec_cmd, uart_set, clr_set;
    logic       dec_unknown;

    cmd_decode u_decode (
        .data_i    (rx_data),
        .cmd_o     (dec_cmd),
        .unknown_o (dec_unknown)
    );

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        uart_set  = (state_q == POP && !dec_unknown) ? dec_cmd : '0;
        clr_set   = (state_q == ISSUE) ? cmd_q : '0;
        // Sets are OR-ed after the clear so a same-cycle set survives.
        pend_d    = (pend_q & ~clr_set) | uart_set
                  | {btn_mode, btn_run, btn_clear};
        case (state_q)
            IDLE: begin
                if (pend_q != '0)   state_d = ISSUE;
                else if (!rx_empty) state_d = POP;
            end
            POP:   state_d = IDLE;
            ISSUE: begin
                state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                gap_cnt_d = '0;
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                else gap_cnt_d = gap_cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
        cmd_d    = (state_d == ISSUE) ? pick_cmd(pend_q) : '0;
        rx_pop_d = (state_d == POP);
        busy_d   = (state_d != IDLE) || (pend_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            cmd_q     <= '0;
            gap_cnt_q <= '0;
            rx_pop_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            cmd_q     <= cmd_d;
            gap_cnt_q <= gap_cnt_d;
            rx_pop_q  <= rx_pop_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_pop  = rx_pop_q;
    assign o_clear = cmd_q[0];
    assign o_run   = cmd_q[1];
    assign o_mode  = cmd_q[2];
    assign o_busy  = busy_q;

`ifdef CMD_SCHEDULER_ERR_EN
    logic       o_err_q, o_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        o_err_d   = (state_q == POP) && dec_unknown;
        err_cnt_d = err_cnt_q;
        if (o_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_err_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            o_err_q   <= o_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err   = o_err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed table-driven bench for cmd_scheduler (GAP_CYCLES=2 and 0),
// with a small show-ahead FIFO model feeding the UART side.
module tb_cmd_scheduler;

    localparam int NV = 70;

    typedef struct packed {
        logic       br, bc, bm, rs, push;
        logic [7:0] pb;
        logic       e_pop, e_run, e_clr, e_mode, e_busy, e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_run = 1'b0, btn_clear = 1'b0, btn_mode = 1'b0;
    logic rx_empty = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic rx_pop, o_run, o_clear, o_mode, o_busy;
    logic rx_empty0 = 1'b1;
    logic [7:0] rx_data0 = 8'h00;
    logic rx_pop0, o_run0, o_clear0, o_mode0, o_busy0;
`ifdef CMD_SCHEDULER_ERR_EN
    logic o_err, o_err0;
    logic [7:0] err_cnt, err_cnt0;
`endif

    always #5 clk = ~clk;

    cmd_scheduler #(.GAP_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(rx_pop),
        .o_run(o_run), .o_clear(o_clear), .o_mode(o_mode),
`ifdef CMD_SCHEDULER_ERR_EN
        .o_err(o_err), .err_cnt(err_cnt),
`endif
        .o_busy(o_busy)
    );

    cmd_scheduler #(.GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_mode(btn_mode),
        .rx_empty(rx_empty0), .rx_data(rx_data0), .rx_pop(rx_pop0),
        .o_run(o_run0), .o_clear(o_clear0), .o_mode(o_mode0),
`ifdef CMD_SCHEDULER_ERR_EN
        .o_err(o_err0), .err_cnt(err_cnt0),
`endif
        .o_busy(o_busy0)
    );

    vec_t vecs [NV];
    logic [7:0] fifo_q [$];
    logic popped;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk1(input string name, input int idx,
                        input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic chk8(input string name, input int idx,
                        input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0d want %0d", name, idx, act, exp);
        end
    endtask

    task automatic refresh_rx();
        rx_empty = (fifo_q.size() == 0);
        if (fifo_q.size() > 0) rx_data = fifo_q[0];
        else rx_data = 8'h00;
    endtask

    // Called at the negedge; pops the FIFO if the DUT popped this cycle.
    task automatic end_cycle();
        popped = rx_pop;
        @(posedge clk);
        #1;
        if (popped && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh_rx();
    endtask

    task automatic busy(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) vecs[k].e_busy = 1'b1;
    endtask

    initial begin
        int guard;
        for (int k = 0; k < NV; k++) vecs[k] = '0;
        vecs[2].br = 1'b1;
        busy(3, 6);
        vecs[4].e_run = 1'b1;
        vecs[8].push = 1'b1; vecs[8].pb = 8'h63;
        vecs[9].push = 1'b1; vecs[9].pb = 8'h6D;
        vecs[9].e_pop = 1'b1;
        busy(9, 13);
        vecs[11].e_clr = 1'b1;
        vecs[15].e_pop = 1'b1;
        busy(15, 19);
        vecs[17].e_mode = 1'b1;
        vecs[22].br = 1'b1; vecs[22].bc = 1'b1; vecs[22].bm = 1'b1;
        busy(23, 34);
        vecs[24].e_clr = 1'b1;
        vecs[28].e_run = 1'b1;
        vecs[32].e_mode = 1'b1;
        vecs[37].br = 1'b1; vecs[37].push = 1'b1; vecs[37].pb = 8'h72;
        vecs[38].e_pop = 1'b1;
        busy(38, 42);
        vecs[40].e_run = 1'b1;
        vecs[45].bc = 1'b1; vecs[45].bm = 1'b1;
        busy(46, 48);
        vecs[47].e_clr = 1'b1;
        vecs[48].rs = 1'b1;
        vecs[57].push = 1'b1; vecs[57].pb = 8'h72;
        vecs[58].e_pop = 1'b1; vecs[58].e_busy = 1'b1; vecs[58].rs = 1'b1;
        vecs[65].push = 1'b1; vecs[65].pb = 8'h41;
        vecs[66].e_pop = 1'b1; vecs[66].e_busy = 1'b1;
        vecs[67].e_err = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk1("rst_pop", r, rx_pop, 1'b0);
            chk1("rst_run", r, o_run, 1'b0);
            chk1("rst_clear", r, o_clear, 1'b0);
            chk1("rst_mode", r, o_mode, 1'b0);
            chk1("rst_busy", r, o_busy, 1'b0);
`ifdef CMD_SCHEDULER_ERR_EN
            chk1("rst_err", r, o_err, 1'b0);
            chk8("rst_err_cnt", r, err_cnt, 8'd0);
`endif
            end_cycle();
        end

        for (int k = 0; k < NV; k++) begin
            rst       = vecs[k].rs;
            btn_run   = vecs[k].br;
            btn_clear = vecs[k].bc;
            btn_mode  = vecs[k].bm;
            if (vecs[k].push) fifo_q.push_back(vecs[k].pb);
            refresh_rx();
            @(negedge clk);
            chk1("rx_pop", k, rx_pop, vecs[k].e_pop);
            chk1("o_run", k, o_run, vecs[k].e_run);
            chk1("o_clear", k, o_clear, vecs[k].e_clr);
            chk1("o_mode", k, o_mode, vecs[k].e_mode);
            chk1("o_busy", k, o_busy, vecs[k].e_busy);
            chk1("pop_empty", k, rx_pop & rx_empty, 1'b0);
`ifdef CMD_SCHEDULER_ERR_EN
            chk1("o_err", k, o_err, vecs[k].e_err);
`endif
            end_cycle();
        end

        // All three buttons at once on both gap settings.
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            btn_run   = (c == 0);
            btn_clear = (c == 0);
            btn_mode  = (c == 0);
            @(negedge clk);
            chk1("g2_clear", c, o_clear, c == 2);
            chk1("g2_run", c, o_run, c == 6);
            chk1("g2_mode", c, o_mode, c == 10);
            chk1("g2_busy", c, o_busy, c >= 1 && c <= 12);
            chk1("g0_clear", c, o_clear0, c == 2);
            chk1("g0_run", c, o_run0, c == 4);
            chk1("g0_mode", c, o_mode0, c == 6);
            chk1("g0_busy", c, o_busy0, c >= 1 && c <= 6);
            chk1("g0_pop", c, rx_pop0, 1'b0);
            end_cycle();
        end
        btn_run = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;

`ifdef CMD_SCHEDULER_ERR_EN
        chk8("err_cnt_one", 0, err_cnt, 8'd1);
        chk8("err_cnt_g0", 0, err_cnt0, 8'd0);
        for (int i = 0; i < 300; i++) fifo_q.push_back(8'h41);
        refresh_rx();
        guard = 0;
        while ((fifo_q.size() > 0 || o_busy) && guard < 2000) begin
            @(negedge clk);
            chk1("err_no_cmd", guard, o_run | o_clear | o_mode, 1'b0);
            chk1("err_pop_empty", guard, rx_pop & rx_empty, 1'b0);
            end_cycle();
            guard++;
        end
        chk1("err_timeout", guard, guard >= 2000, 1'b0);
        chk8("err_cnt_sat", 0, err_cnt, 8'd255);
`else
        guard = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
